// File: rtl/bus_fabric.sv
// -----------------------------------------------------------------------------
// bus_fabric
//
// Purpose:
//   Address decoder and read sequencer between a single CPU master and up to
//   eight memory-mapped slaves.  Writes go straight through to the decoded
//   slave in the same cycle.  Reads are sequenced by a small FSM that inserts
//   the selected slave's wait states and registers the returned data.
//   An unmapped read finishes with zero wait states and returns all-ones data.
//
// Parameters:
//   NUM_SLAVES  number of decoded slave ports (1..8)
//   ADDR_W      CPU address width
//   DATA_W      data width
//   SLV_BASE    packed per-slave base addresses (slave 0 in the LSBs)
//   SLV_MASK    packed per-slave compare masks
//   SLV_WAIT    packed per-slave read wait states, 4 bits each (0..15)
//
// Ports:
//   clk          single clock for all logic
//   reset        asynchronous, active-high reset
//   cpu_addr     CPU address (held stable by the CPU while cpu_ready is low)
//   cpu_rd_req   one-cycle read request pulse
//   cpu_wr_en    write strobe
//   cpu_wr_data  write data
//   cpu_rd_data  registered read data, held until the next completed read
//   cpu_ready    high when the bus is idle and cpu_rd_data is valid
//   slv_cs       one-hot (or zero) chip selects
//   slv_wr_en    per-slave gated write strobes
//   slv_wr_data  write data broadcast to every slave
//   slv_rd_data  packed slave read data (slave 0 in the LSBs)
//   bus_err      one-cycle error pulse
//   err_count    saturating error counter
//
// Build option:
//   BUS_FABRIC_ERR_EN  when defined, builds the error pulse and the saturating
//                      error counter; otherwise bus_err and err_count are 0.
// -----------------------------------------------------------------------------
module bus_fabric #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {16'hC000, 16'h9200, 16'h8000, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    {16'hC000, 16'hFF00, 16'hF000, 16'h8000},
  parameter logic [NUM_SLAVES*4-1:0] SLV_WAIT =
    {4'd0, 4'd1, 4'd0, 4'd0}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic                         cpu_rd_req,
  input  logic                         cpu_wr_en,
  input  logic [DATA_W-1:0]            cpu_wr_data,
  output logic [DATA_W-1:0]            cpu_rd_data,
  output logic                         cpu_ready,
  output logic [NUM_SLAVES-1:0]        slv_cs,
  output logic [NUM_SLAVES-1:0]        slv_wr_en,
  output logic [DATA_W-1:0]            slv_wr_data,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rd_data,
  output logic                         bus_err,
  output logic [7:0]                   err_count
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  lat_idx;
  logic [IDX_W-1:0]  lat_idx_nxt;
  logic              lat_hit;
  logic              lat_hit_nxt;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_cnt_nxt;
  logic              capture;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] sel_rd_data;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic [3:0]        dec_wait;
  logic              rd_start;

  // Address decode.  Scanning from the highest index down lets the lowest
  // matching slave overwrite any higher match, so it wins the priority.
  always_comb begin
    dec_hit  = 1'b0;
    dec_idx  = '0;
    dec_wait = 4'd0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit  = 1'b1;
        dec_idx  = IDX_W'(i);
        dec_wait = SLV_WAIT[i*4 +: 4];
      end
    end
  end

  // In IDLE the chip select tracks the live decode so writes need no wait
  // states; once a read is in flight it follows the latched slave instead.
  always_comb begin
    slv_cs = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (state == IDLE) begin
        slv_cs[i] = dec_hit && (dec_idx == IDX_W'(i));
      end else begin
        slv_cs[i] = lat_hit && (lat_idx == IDX_W'(i));
      end
    end
  end

  assign slv_wr_en   = slv_cs & {NUM_SLAVES{cpu_wr_en}};
  assign slv_wr_data = cpu_wr_data;

  // Read data of the latched slave; an unmapped read returns all ones.
  always_comb begin
    sel_rd_data = '1;
    if (lat_hit) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (lat_idx == IDX_W'(i)) begin
          sel_rd_data = slv_rd_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // A write in the same cycle takes precedence, so the read is dropped.
  assign rd_start = (state == IDLE) && cpu_rd_req && !cpu_wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_idx   <= '0;
      lat_hit   <= 1'b0;
      wait_cnt  <= 4'd0;
      rd_data_q <= '0;
    end else begin
      state    <= state_nxt;
      lat_idx  <= lat_idx_nxt;
      lat_hit  <= lat_hit_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (capture) begin
        rd_data_q <= sel_rd_data;
      end
    end
  end

  // Read sequencer.  WAIT always lasts at least one cycle, so a slave with N
  // wait states keeps cpu_ready low for N+1 WAIT cycles plus one DONE cycle.
  always_comb begin
    state_nxt    = state;
    lat_idx_nxt  = lat_idx;
    lat_hit_nxt  = lat_hit;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_start) begin
          state_nxt    = WAIT;
          lat_idx_nxt  = dec_idx;
          lat_hit_nxt  = dec_hit;
          wait_cnt_nxt = dec_wait;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      DONE: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cpu_ready   = (state == IDLE);
  assign cpu_rd_data = rd_data_q;

`ifdef BUS_FABRIC_ERR_EN
  logic       err_event;
  logic [7:0] err_cnt_q;

  // Several error causes can coincide in one cycle; they still count once.
  assign err_event = ((state == DONE) && !lat_hit)
                   || (cpu_wr_en && (slv_cs == '0))
                   || (cpu_rd_req && ((state != IDLE) || cpu_wr_en));

  // The pulse is combinational so an unmapped write flags in its own cycle;
  // gating with reset keeps it low while reset is held.
  assign bus_err = err_event && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (err_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign bus_err   = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// -----------------------------------------------------------------------------
// tb_bus_fabric
//
// Self-checking bench for bus_fabric with default parameters.  Expected values
// come from a reference model that decodes addresses from the memory map table
// and predicts latency (wait states + 2), returned data and error counts.
// -----------------------------------------------------------------------------
module tb_bus_fabric;

`ifdef BUS_FABRIC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_rd_req;
  logic        cpu_wr_en;
  logic [7:0]  cpu_wr_data;
  logic [7:0]  cpu_rd_data;
  logic        cpu_ready;
  logic [3:0]  slv_cs;
  logic [3:0]  slv_wr_en;
  logic [7:0]  slv_wr_data;
  logic [31:0] slv_rd_data;
  logic        bus_err;
  logic [7:0]  err_count;

  int          n_checks;
  int          n_fail;
  int          exp_err;
  logic [7:0]  last_data;

  // Memory map of the default build, slave 0 first.
  logic [15:0] map_base [4];
  logic [15:0] map_mask [4];
  int          map_wait [4];

  bus_fabric dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_rd_req  (cpu_rd_req),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_ready   (cpu_ready),
    .slv_cs      (slv_cs),
    .slv_wr_en   (slv_wr_en),
    .slv_wr_data (slv_wr_data),
    .slv_rd_data (slv_rd_data),
    .bus_err     (bus_err),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int modelDecode(input logic [15:0] addr);
    for (int i = 0; i < 4; i++) begin
      if ((addr & map_mask[i]) == map_base[i]) return i;
    end
    return -1;
  endfunction

  function automatic void bumpErr();
    if (ERR_EN && exp_err < 255) exp_err = exp_err + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic rd,
                               input logic wr, input logic [7:0] wdata);
    cpu_addr    = addr;
    cpu_rd_req  = rd;
    cpu_wr_en   = wr;
    cpu_wr_data = wdata;
  endtask

  task automatic doRead(input logic [15:0] addr, input logic [31:0] rdata,
                        input bit extra_req, input string tag);
    int         idx;
    int         low;
    int         exp_low;
    logic [3:0] exp_cs;
    logic [7:0] exp_data;
    idx      = modelDecode(addr);
    exp_cs   = (idx < 0) ? 4'b0000 : 4'(1 << idx);
    exp_data = (idx < 0) ? 8'hFF : 8'(rdata >> (8 * idx));
    exp_low  = (idx < 0) ? 2 : map_wait[idx] + 2;
    slv_rd_data = rdata;
    applyStimulus(addr, 1'b1, 1'b0, 8'h00);
    #1;
    checkOutput({tag, "_cs"}, 32'(slv_cs), 32'(exp_cs));
    @(posedge clk); #1;
    cpu_rd_req = extra_req;
    if (extra_req) bumpErr();
    checkOutput({tag, "_cs_hold"}, 32'(slv_cs), 32'(exp_cs));
    low = 0;
    while (cpu_ready !== 1'b1 && low < 40) begin
      low++;
      @(posedge clk); #1;
      cpu_rd_req = 1'b0;
    end
    if (idx < 0) bumpErr();
    checkOutput({tag, "_ready_low"}, 32'(low), 32'(exp_low));
    checkOutput({tag, "_data"}, 32'(cpu_rd_data), 32'(exp_data));
    checkOutput({tag, "_errcnt"}, 32'(err_count), 32'(exp_err));
    last_data = exp_data;
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [7:0] wdata,
                         input bit with_rd, input string tag);
    int         idx;
    logic [3:0] exp_cs;
    bit         err_now;
    idx     = modelDecode(addr);
    exp_cs  = (idx < 0) ? 4'b0000 : 4'(1 << idx);
    err_now = ERR_EN && ((idx < 0) || with_rd);
    applyStimulus(addr, with_rd, 1'b1, wdata);
    #1;
    checkOutput({tag, "_wr_en"}, 32'(slv_wr_en), 32'(exp_cs));
    checkOutput({tag, "_wr_data"}, 32'(slv_wr_data), 32'(wdata));
    checkOutput({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'(err_now));
    @(posedge clk); #1;
    if ((idx < 0) || with_rd) bumpErr();
    applyStimulus(addr, 1'b0, 1'b0, 8'h00);
    #1;
    checkOutput({tag, "_no_read"}, 32'(cpu_ready), 32'd1);
    checkOutput({tag, "_rd_hold"}, 32'(cpu_rd_data), 32'(last_data));
    checkOutput({tag, "_errcnt"}, 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    map_base = '{16'h0000, 16'h8000, 16'h9200, 16'hC000};
    map_mask = '{16'h8000, 16'hF000, 16'hFF00, 16'hC000};
    map_wait = '{0, 0, 1, 0};
    n_checks  = 0;
    n_fail    = 0;
    exp_err   = 0;
    last_data = 8'h00;
    slv_rd_data = 32'h0;
    reset = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 8'h00);

    #3;
    checkOutput("reset_ready", 32'(cpu_ready), 32'd1);
    checkOutput("reset_rd_data", 32'(cpu_rd_data), 32'd0);
    checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    doRead(16'h1234, 32'h112233A5, 1'b0, "rd_1234");
    doRead(16'h9203, 32'h773C5566, 1'b1, "rd_9203");
    doWrite(16'h9000, 8'h55, 1'b0, "wr_9000");
    doRead(16'h9100, 32'h12345678, 1'b0, "rd_9100");
    doWrite(16'h8010, 8'h99, 1'b1, "rdwr_8010");
    doRead(16'hC001, 32'hDEADBEEF, 1'b0, "rd_c001");

    for (int k = 0; k < 40; k++) begin
      logic [15:0] a;
      int          op;
      a  = 16'($urandom);
      op = $urandom_range(0, 3);
      if (op < 2) doRead(a, $urandom, bit'($urandom_range(0, 1)), "rand_rd");
      else        doWrite(a, 8'($urandom), op == 3, "rand_wr");
    end

    // Reset in the WAIT state of a slow slave read.
    slv_rd_data = 32'h00AB0000;
    applyStimulus(16'h9280, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1;
    applyStimulus(16'h9280, 1'b0, 1'b0, 8'h00);
    checkOutput("mid_read_busy", 32'(cpu_ready), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(cpu_ready), 32'd1);
    checkOutput("abort_rd_data", 32'(cpu_rd_data), 32'd0);
    checkOutput("abort_bus_err", 32'(bus_err), 32'd0);
    checkOutput("abort_err_count", 32'(err_count), 32'd0);
    exp_err   = 0;
    last_data = 8'h00;
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_stays_idle", 32'(cpu_ready), 32'd1);
    checkOutput("abort_no_capture", 32'(cpu_rd_data), 32'd0);
    doRead(16'h92F0, 32'h00C30000, 1'b0, "rd_after_abort");

    // Error counter saturation.
    for (int k = 0; k < 300; k++) begin
      applyStimulus(16'h9000, 1'b0, 1'b1, 8'h55);
      @(posedge clk); #1;
      bumpErr();
    end
    applyStimulus(16'h0000, 1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("err_saturate", 32'(err_count), 32'(exp_err));
    checkOutput("final_rd_hold", 32'(cpu_rd_data), 32'(last_data));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
